// File: rtl/loopval_crf_pkg.sv
// Shared CGRA definitions for the loop-value control register file.
// Holds the request op encoding, cfg write targets and default geometry.
package loopval_crf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int NREG_DEF   = 32;
    localparam int IDX_W      = 5;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_INIT = 2'b01,
        OP_STEP = 2'b10
    } op_e;

    localparam logic [1:0] CFG_SEL_VALUE = 2'b00;
    localparam logic [1:0] CFG_SEL_INIT  = 2'b01;
    localparam logic [1:0] CFG_SEL_STEP  = 2'b10;

endpackage

// File: rtl/loopval_crf_if.sv
// Bundle of update-request, configuration and operand-read signals.
// jmp_trigger is a one-cycle active-low strobe with no ready: every request is accepted.
interface loopval_crf_if #(
    parameter int DATA_W = 32
);
    import loopval_crf_pkg::*;

    logic              jmp_trigger;
    logic              jmp_init;
    logic [IDX_W-1:0]  jmp_index;
    logic              cfg_we;
    logic [1:0]        cfg_sel;
    logic [IDX_W-1:0]  cfg_addr;
    logic [DATA_W-1:0] cfg_data;
    logic [IDX_W-1:0]  rd_addr_a;
    logic [IDX_W-1:0]  rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              upd_busy;
    logic              upd_done;
    logic [IDX_W-1:0]  upd_idx;

    modport master (
        output jmp_trigger, jmp_init, jmp_index,
        output cfg_we, cfg_sel, cfg_addr, cfg_data,
        output rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, upd_busy, upd_done, upd_idx
    );

    modport slave (
        input  jmp_trigger, jmp_init, jmp_index,
        input  cfg_we, cfg_sel, cfg_addr, cfg_data,
        input  rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, upd_busy, upd_done, upd_idx
    );

endinterface

// File: rtl/loopval_crf_crf_bank.sv
// Value/init/step storage with two operand read ports, a request lookup port,
// one pipeline update port and one cfg write port.
module crf_bank
    import loopval_crf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [IDX_W-1:0]  rd_addr_a,
    input  logic [IDX_W-1:0]  rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic [IDX_W-1:0]  lk_addr,
    output logic [DATA_W-1:0] lk_value,
    output logic [DATA_W-1:0] lk_init,
    output logic [DATA_W-1:0] lk_step,
    input  logic              upd_we,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic [DATA_W-1:0] upd_data,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [IDX_W-1:0]  cfg_addr,
    input  logic [DATA_W-1:0] cfg_data
);

    logic [DATA_W-1:0] value_q [NREG];
    logic [DATA_W-1:0] value_d [NREG];
    logic [DATA_W-1:0] init_q  [NREG];
    logic [DATA_W-1:0] init_d  [NREG];
    logic [DATA_W-1:0] step_q  [NREG];
    logic [DATA_W-1:0] step_d  [NREG];

    function automatic logic in_range(input logic [IDX_W-1:0] a);
        return int'(a) < NREG;
    endfunction

    assign rd_data_a = in_range(rd_addr_a) ? value_q[rd_addr_a] : '0;
    assign rd_data_b = in_range(rd_addr_b) ? value_q[rd_addr_b] : '0;
    assign lk_value  = in_range(lk_addr)   ? value_q[lk_addr]   : '0;
    assign lk_init   = in_range(lk_addr)   ? init_q[lk_addr]    : '0;
    assign lk_step   = in_range(lk_addr)   ? step_q[lk_addr]    : '0;

    always_comb begin
        value_d = value_q;
        init_d  = init_q;
        step_d  = step_q;
        if (cfg_we && in_range(cfg_addr)) begin
            case (cfg_sel)
                CFG_SEL_VALUE: value_d[cfg_addr] = cfg_data;
                CFG_SEL_INIT:  init_d[cfg_addr]  = cfg_data;
                CFG_SEL_STEP:  step_d[cfg_addr]  = cfg_data;
                default:       ;
            endcase
        end
        // Applied after the cfg write so a same-edge commit overrides it.
        if (upd_we && in_range(upd_idx)) begin
            value_d[upd_idx] = upd_data;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NREG; i++) begin
                value_q[i] <= '0;
                init_q[i]  <= '0;
                step_q[i]  <= '0;
            end
        end else begin
            value_q <= value_d;
            init_q  <= init_d;
            step_q  <= step_d;
        end
    end

endmodule

// File: rtl/loopval_crf.sv
// Loop-value CRF: decodes hardware-loop INIT/STEP requests and commits them
// through a two-stage pipeline with same-index forwarding into S1.
module loopval_crf
    import loopval_crf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    loopval_crf_if.slave  bus
);

    logic              req_valid;
    op_e               req_op;
    logic [DATA_W-1:0] lk_value;
    logic [DATA_W-1:0] lk_init;
    logic [DATA_W-1:0] lk_step;
    logic [DATA_W-1:0] cur_value;
    logic [DATA_W-1:0] s1_result;

    logic              s1_valid_q, s1_valid_d;
    op_e               s1_op_q,    s1_op_d;
    logic [IDX_W-1:0]  s1_idx_q,   s1_idx_d;
    logic [DATA_W-1:0] s1_value_q, s1_value_d;
    logic [DATA_W-1:0] s1_init_q,  s1_init_d;
    logic [DATA_W-1:0] s1_step_q,  s1_step_d;
    logic              upd_done_q, upd_done_d;
    logic [IDX_W-1:0]  upd_idx_q,  upd_idx_d;

    crf_bank #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_bank (
        .Clk       (Clk),
        .Reset     (Reset),
        .rd_addr_a (bus.rd_addr_a),
        .rd_addr_b (bus.rd_addr_b),
        .rd_data_a (bus.rd_data_a),
        .rd_data_b (bus.rd_data_b),
        .lk_addr   (bus.jmp_index),
        .lk_value  (lk_value),
        .lk_init   (lk_init),
        .lk_step   (lk_step),
        .upd_we    (s1_valid_q),
        .upd_idx   (s1_idx_q),
        .upd_data  (s1_result),
        .cfg_we    (bus.cfg_we),
        .cfg_sel   (bus.cfg_sel),
        .cfg_addr  (bus.cfg_addr),
        .cfg_data  (bus.cfg_data)
    );

    always_comb begin
        req_valid = !bus.jmp_trigger;
        req_op    = OP_NONE;
        if (!bus.jmp_trigger) begin
            req_op = bus.jmp_init ? OP_STEP : OP_INIT;
        end
    end

    // STEP wraps modulo 2^DATA_W; the carry out is dropped on purpose.
    assign s1_result = (s1_op_q == OP_INIT) ? s1_init_q : s1_value_q + s1_step_q;

    // The stored value lags S1 by one edge, so a back-to-back request takes S1's result.
    assign cur_value = (s1_valid_q && (s1_idx_q == bus.jmp_index)) ? s1_result : lk_value;

    always_comb begin
        s1_valid_d = req_valid;
        s1_op_d    = req_op;
        s1_idx_d   = bus.jmp_index;
        s1_value_d = cur_value;
        s1_init_d  = lk_init;
        s1_step_d  = lk_step;
        upd_done_d = s1_valid_q;
        upd_idx_d  = s1_valid_q ? s1_idx_q : upd_idx_q;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OP_NONE;
            s1_idx_q   <= '0;
            s1_value_q <= '0;
            s1_init_q  <= '0;
            s1_step_q  <= '0;
            upd_done_q <= 1'b0;
            upd_idx_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_idx_q   <= s1_idx_d;
            s1_value_q <= s1_value_d;
            s1_init_q  <= s1_init_d;
            s1_step_q  <= s1_step_d;
            upd_done_q <= upd_done_d;
            upd_idx_q  <= upd_idx_d;
        end
    end

    assign bus.upd_busy = s1_valid_q | upd_done_q;
    assign bus.upd_done = upd_done_q;
    assign bus.upd_idx  = upd_idx_q;

endmodule

// File: tb/tb_loopval_crf.sv
// Directed and randomized bench for loopval_crf against an architectural model:
// requests apply in order to a logical value array and become visible one edge later.
module tb_loopval_crf;

    localparam int W = 32;
    localparam int N = 32;

    typedef struct {
        logic [4:0]   idx;
        logic [W-1:0] val;
    } commit_t;

    logic Clk;
    logic Reset;

    loopval_crf_if #(.DATA_W(W)) bus ();

    loopval_crf #(.DATA_W(W), .NREG(N)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- reference model / scoreboard ----------------
    logic [W-1:0] arch_val [N];
    logic [W-1:0] vis_val  [N];
    logic [W-1:0] m_init   [N];
    logic [W-1:0] m_step   [N];
    commit_t      commit_q [$];
    logic [W-1:0] exp_q    [$];
    logic         exp_done;
    logic [4:0]   exp_idx;
    int           tests_run;
    int           tests_failed;
    int           done_cnt;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            arch_val[i] = '0;
            vis_val[i]  = '0;
            m_init[i]   = '0;
            m_step[i]   = '0;
        end
        commit_q.delete();
        exp_done = 1'b0;
        exp_idx  = '0;
    endtask

    task automatic model_edge();
        logic       c_hit;
        logic [4:0] c_idx;
        logic       r_hit;
        logic [4:0] r_idx;
        commit_t    e;
        c_hit = 1'b0;
        c_idx = '0;
        r_hit = 1'b0;
        r_idx = bus.jmp_index;
        if (!Reset) begin
            model_reset();
            return;
        end
        exp_done = 1'b0;
        if (commit_q.size() != 0) begin
            e = commit_q.pop_front();
            vis_val[e.idx] = e.val;
            c_hit    = 1'b1;
            c_idx    = e.idx;
            exp_done = 1'b1;
            exp_idx  = e.idx;
        end
        if (!bus.jmp_trigger) begin
            r_hit = 1'b1;
            if (!bus.jmp_init) arch_val[r_idx] = m_init[r_idx];
            else               arch_val[r_idx] = arch_val[r_idx] + m_step[r_idx];
            e.idx = r_idx;
            e.val = arch_val[r_idx];
            commit_q.push_back(e);
        end
        if (bus.cfg_we) begin
            case (bus.cfg_sel)
                2'b00: if (!(c_hit && c_idx == bus.cfg_addr)) begin
                    vis_val[bus.cfg_addr] = bus.cfg_data;
                    if (!(r_hit && r_idx == bus.cfg_addr)) arch_val[bus.cfg_addr] = bus.cfg_data;
                end
                2'b01: m_init[bus.cfg_addr] = bus.cfg_data;
                2'b10: m_step[bus.cfg_addr] = bus.cfg_data;
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs();
        if (bus.upd_done === 1'b1) done_cnt++;
        check("rd_data_a", bus.rd_data_a, vis_val[bus.rd_addr_a]);
        check("rd_data_b", bus.rd_data_b, vis_val[bus.rd_addr_b]);
        check("upd_done", W'(bus.upd_done), W'(exp_done));
        check("upd_busy", W'(bus.upd_busy), W'((commit_q.size() != 0) || exp_done));
        if (exp_done) check("upd_idx", W'(bus.upd_idx), W'(exp_idx));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        check_outputs();
    endtask

    task automatic drive_idle();
        bus.jmp_trigger = 1'b1;
        bus.jmp_init    = 1'b1;
        bus.jmp_index   = '0;
        bus.cfg_we      = 1'b0;
        bus.cfg_sel     = 2'b00;
        bus.cfg_addr    = '0;
        bus.cfg_data    = '0;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [4:0] addr, input logic [W-1:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = sel;
        bus.cfg_addr = addr;
        bus.cfg_data = data;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic set_req(input logic is_init, input logic [4:0] idx);
        bus.jmp_trigger = 1'b0;
        bus.jmp_init    = !is_init;
        bus.jmp_index   = idx;
    endtask

    task automatic request(input logic is_init, input logic [4:0] idx);
        set_req(is_init, idx);
        tick();
        bus.jmp_trigger = 1'b1;
        bus.jmp_init    = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        tests_run    = 0;
        tests_failed = 0;
        done_cnt     = 0;
        Reset        = 1'b0;
        drive_idle();
        bus.rd_addr_a = 5'd0;
        bus.rd_addr_b = 5'd1;
        model_reset();

        // reset state
        @(negedge Clk);
        @(negedge Clk);
        check("reset_done", W'(bus.upd_done), '0);
        check("reset_busy", W'(bus.upd_busy), '0);
        check("reset_idx",  W'(bus.upd_idx),  '0);
        check("reset_rd_a", bus.rd_data_a, '0);
        Reset = 1'b1;
        tick();

        // basic STEP x3 then INIT
        bus.rd_addr_a = 5'd3;
        cfg_write(2'b01, 5'd3, 32'd10);
        cfg_write(2'b10, 5'd3, 32'd2);
        cfg_write(2'b00, 5'd3, 32'd10);
        base = done_cnt;
        request(1'b0, 5'd3);
        tick();
        request(1'b0, 5'd3);
        tick();
        request(1'b0, 5'd3);
        tick();
        tick();
        check("step_value", bus.rd_data_a, 32'd16);
        check("step_pulses", W'(done_cnt - base), 32'd3);
        request(1'b1, 5'd3);
        tick();
        check("init_value", bus.rd_data_a, 32'd10);

        // forwarding across four consecutive STEPs
        bus.rd_addr_a = 5'd5;
        cfg_write(2'b00, 5'd5, 32'd0);
        cfg_write(2'b10, 5'd5, 32'd1);
        exp_q = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
        set_req(1'b0, 5'd5);
        check("fwd_rd", bus.rd_data_a, exp_q.pop_front());
        for (int k = 0; k < 5; k++) begin
            if (k == 4) drive_idle();
            tick();
            check("fwd_rd", bus.rd_data_a, exp_q.pop_front());
        end

        // wrap-around
        bus.rd_addr_a = 5'd7;
        cfg_write(2'b00, 5'd7, 32'hFFFF_FFFE);
        cfg_write(2'b10, 5'd7, 32'd3);
        request(1'b0, 5'd7);
        tick();
        check("wrap_value", bus.rd_data_a, 32'h0000_0001);

        // cfg value write colliding with a commit
        bus.rd_addr_a = 5'd2;
        cfg_write(2'b00, 5'd2, 32'd4);
        cfg_write(2'b10, 5'd2, 32'd1);
        request(1'b0, 5'd2);
        cfg_write(2'b00, 5'd2, 32'd99);
        tick();
        check("collide_value", bus.rd_data_a, 32'd5);

        // reset mid-operation
        bus.rd_addr_a = 5'd1;
        cfg_write(2'b00, 5'd1, 32'd7);
        cfg_write(2'b10, 5'd1, 32'd1);
        base = done_cnt;
        request(1'b0, 5'd1);
        Reset = 1'b0;
        model_reset();
        #1;
        check("midrst_busy", W'(bus.upd_busy), '0);
        check("midrst_done", W'(bus.upd_done), '0);
        tick();
        tick();
        Reset = 1'b1;
        tick();
        tick();
        tick();
        check("midrst_pulses", W'(done_cnt - base), '0);
        check("midrst_value", bus.rd_data_a, '0);
        check("midrst_busy_after", W'(bus.upd_busy), '0);

        // jmp_init low without trigger is a no-op
        cfg_write(2'b00, 5'd3, 32'd10);
        cfg_write(2'b10, 5'd3, 32'd2);
        bus.rd_addr_a = 5'd3;
        base = done_cnt;
        bus.jmp_trigger = 1'b1;
        bus.jmp_init    = 1'b0;
        bus.jmp_index   = 5'd3;
        for (int k = 0; k < 4; k++) tick();
        drive_idle();
        check("noop_pulses", W'(done_cnt - base), '0);
        check("noop_value", bus.rd_data_a, 32'd10);

        // randomized traffic over a small index set to exercise forwarding
        for (int n = 0; n < 400; n++) begin
            bus.jmp_trigger = 1'($urandom_range(0, 1));
            bus.jmp_init    = 1'($urandom_range(0, 3) != 0);
            bus.jmp_index   = 5'($urandom_range(0, 3));
            bus.cfg_we      = 1'($urandom_range(0, 2) == 0);
            bus.cfg_sel     = 2'($urandom_range(0, 3));
            bus.cfg_addr    = 5'($urandom_range(0, 3));
            bus.cfg_data    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
            bus.rd_addr_a   = 5'($urandom_range(0, 3));
            bus.rd_addr_b   = 5'($urandom_range(0, 3));
            tick();
        end
        drive_idle();
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.rd_addr_a = 5'(i);
            #1;
            check("final_value", bus.rd_data_a, vis_val[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
